// File: rtl/divider_if.sv
// Request/result bundle for the iterative divider.
//
// Handshake: the master raises div_begin with the operands valid and holds it
// high until it sees div_end. The divider samples the operands on the first
// edge it sees div_begin while idle, and raises div_end once the result is
// stable. Results stay valid for as long as div_begin stays high. Lowering
// div_begin after div_end completes the transfer. Lowering it before div_end
// aborts the operation. The master must keep div_begin low for at least one
// cycle between operations.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             div_begin;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             div_end;

    modport master (
        output div_begin, div_signed, dividend, divisor,
        input  quotient, remainder, div_zero, div_end
    );

    modport slave (
        input  div_begin, div_signed, dividend, divisor,
        output quotient, remainder, div_zero, div_end
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed operands are reduced to magnitudes up front. The signs are
// re-applied when the result is loaded. Dividing by zero returns all ones as
// the quotient and the untouched dividend as the remainder.
// fsm_state exposes the control state for debug: 0 = IDLE, 1 = BUSY, 2 = DONE.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    divider_if.slave   bus,
    output logic [1:0] fsm_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;        // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] dd;         // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dv_mag;     // divisor magnitude
    logic [WIDTH-1:0] dd_raw;     // original dividend, returned on divide-by-zero
    logic             dv_zero;
    logic             sign_q;
    logic             sign_r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_zero_r;
    logic             div_end_r;

    // Operand magnitudes at request time.
    logic             in_dd_neg;
    logic             in_dv_neg;
    logic [WIDTH-1:0] in_dd_mag;
    logic [WIDTH-1:0] in_dv_mag;

    // One restoring step. The trial value is WIDTH+1 bits wide. Its top bit is
    // the borrow that says the subtraction went negative.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dd_next;

    // Final results with the signs applied, used on the last iteration.
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitude selection. Only signed requests with MSB set are negated.
    always_comb begin
        in_dd_neg = bus.div_signed & bus.dividend[WIDTH-1];
        in_dv_neg = bus.div_signed & bus.divisor[WIDTH-1];
        in_dd_mag = in_dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        in_dv_mag = in_dv_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    end

    // Shift, trial-subtract and restore for the current iteration.
    always_comb begin
        shifted  = {rem, dd[WIDTH-1]};
        trial    = shifted - {1'b0, dv_mag};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dd_next  = {dd[WIDTH-2:0], q_bit};
    end

    // Result formatting: sign fix-up, or the fixed divide-by-zero pattern.
    always_comb begin
        q_final = '1;
        r_final = dd_raw;
        if (!dv_zero) begin
            q_final = sign_q ? (~dd_next + 1'b1) : dd_next;
            r_final = sign_r ? (~rem_next + 1'b1) : rem_next;
        end
    end

    // Control FSM together with the datapath and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            rem         <= '0;
            dd          <= '0;
            dv_mag      <= '0;
            dd_raw      <= '0;
            dv_zero     <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            div_end_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_end_r <= 1'b0;
                    if (bus.div_begin) begin
                        dd      <= in_dd_mag;
                        dv_mag  <= in_dv_mag;
                        dd_raw  <= bus.dividend;
                        dv_zero <= (bus.divisor == '0);
                        sign_q  <= in_dd_neg ^ in_dv_neg;
                        sign_r  <= in_dd_neg;
                        rem     <= '0;
                        count   <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.div_begin) begin
                        // Aborted: results from the previous operation stay put.
                        state <= IDLE;
                    end else begin
                        rem   <= rem_next;
                        dd    <= dd_next;
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            quotient_r  <= q_final;
                            remainder_r <= r_final;
                            div_zero_r  <= dv_zero;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.div_begin) begin
                        div_end_r <= 1'b1;
                    end else begin
                        div_end_r <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    div_end_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.div_end   = div_end_r;
    assign fsm_state     = state;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, aborts, resets and random ops.
module tb_divider;
    localparam int WIDTH = 32;
    localparam int RW    = 2 * WIDTH + 1;    // {div_zero, quotient, remainder}
    localparam int LAT   = WIDTH + 1;        // edges after the sampling edge

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] fsm_state;

    divider_if #(.WIDTH(WIDTH)) bus();

    divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_res;
    logic [RW-1:0] mon_e;
    logic          prev_end = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain integer division with truncation toward zero
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        logic [WIDTH-1:0] qv, rv;
        if (b == '0) return {1'b1, {WIDTH{1'b1}}, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q[WIDTH-1:0];
        rv = r[WIDTH-1:0];
        return {1'b0, qv, rv};
    endfunction

    // Monitor: compare on each rising div_end
    always @(negedge clk) begin
        if (bus.div_end && !prev_end) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_end actual=div_end expected=no result pending");
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", bus.quotient, mon_e[2*WIDTH-1:WIDTH]);
                check("remainder", bus.remainder, mon_e[WIDTH-1:0]);
                check("div_zero", WIDTH'(bus.div_zero), WIDTH'(mon_e[2*WIDTH]));
            end
        end
        prev_end <= bus.div_end;
    end

    // Driver: one complete operation, called at a negedge
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sgn, input logic [RW-1:0] exp, input int hold);
        int cycles;
        exp_q.push_back(exp);
        last_res       = exp;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = sgn;
        bus.div_begin  = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 2) begin
                // Operands are ignored once the operation is under way
                bus.dividend   = $urandom;
                bus.divisor    = $urandom;
                bus.div_signed = ~sgn;
            end
        end while (!bus.div_end && cycles < 100);
        check("latency", WIDTH'(cycles), WIDTH'(LAT + 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("end_hold", WIDTH'(bus.div_end), WIDTH'(1));
            check("q_hold", bus.quotient, exp[2*WIDTH-1:WIDTH]);
        end
        bus.div_begin = 1'b0;
        @(negedge clk);
        check("end_drop", WIDTH'(bus.div_end), WIDTH'(0));
    endtask

    // Driver: start an operation and kill it by dropping div_begin or by reset
    task automatic abort_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sgn, input int at_cycle, input bit use_reset);
        int seen_end;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = sgn;
        bus.div_begin  = 1'b1;
        repeat (at_cycle) @(negedge clk);
        bus.div_begin = 1'b0;
        if (use_reset) begin
            resetn = 1'b0;
            repeat (2) @(negedge clk);
            check("rst_quotient", bus.quotient, '0);
            check("rst_remainder", bus.remainder, '0);
            check("rst_div_zero", WIDTH'(bus.div_zero), '0);
            resetn   = 1'b1;
            last_res = '0;
        end else begin
            @(negedge clk);
            check("abort_quotient", bus.quotient, last_res[2*WIDTH-1:WIDTH]);
            check("abort_remainder", bus.remainder, last_res[WIDTH-1:0]);
            check("abort_div_zero", WIDTH'(bus.div_zero), WIDTH'(last_res[2*WIDTH]));
        end
        check("abort_idle", WIDTH'(fsm_state), WIDTH'(0));
        seen_end = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_end) seen_end++;
        end
        check("abort_no_end", WIDTH'(seen_end), WIDTH'(0));
    endtask

    // Main sequence
    initial begin
        logic [WIDTH-1:0] a, b;
        logic             sgn;
        int               kind;

        bus.div_begin  = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        last_res       = '0;
        repeat (3) @(negedge clk);
        check("reset_quotient", bus.quotient, '0);
        check("reset_remainder", bus.remainder, '0);
        check("reset_div_zero", WIDTH'(bus.div_zero), '0);
        check("reset_div_end", WIDTH'(bus.div_end), '0);
        check("reset_state", WIDTH'(fsm_state), '0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        run_op(32'd100, 32'd7, 1'b0, {1'b0, 32'd14, 32'd2}, 2);
        run_op(-32'sd7, 32'd2, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF}, 0);
        run_op(32'd7, -32'sd2, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'd1}, 1);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, {1'b0, 32'h0FFF_FFFF, 32'hF}, 0);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b1, {1'b0, 32'h0, 32'hFFFF_FFFF}, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h8000_0000, 32'h0}, 0);
        run_op(32'h1234_5678, 32'h0, 1'b1, {1'b1, 32'hFFFF_FFFF, 32'h1234_5678}, 1);
        run_op(32'h1234_5678, 32'h0, 1'b0, {1'b1, 32'hFFFF_FFFF, 32'h1234_5678}, 0);

        // Abort by dropping div_begin, then a clean operation
        abort_op(32'd5000, 32'd3, 1'b0, 10, 1'b0);
        run_op(32'd100, 32'd7, 1'b0, {1'b0, 32'd14, 32'd2}, 0);

        // Abort by reset mid-operation, then a clean operation
        abort_op(32'hDEAD_BEEF, 32'd9, 1'b1, 20, 1'b1);
        run_op(32'd100, 32'd7, 1'b0, {1'b0, 32'd14, 32'd2}, 0);

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case (kind)
                0: b = '0;
                1: b = WIDTH'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? '1 : WIDTH'($urandom_range(1, 7)); end
                3: b = {1'b1, 31'($urandom_range(0, 3))};
                default: ;
            endcase
            run_op(a, b, sgn, model(a, b, sgn), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        check("queue_empty", WIDTH'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
